// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: load/recirculate control, round index and output handshake for the iterative AES core
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_fifo_empty,
  input  logic       i_key_ready,
  input  logic       i_clear,
  input  logic       i_out_ready,
  output logic       o_read_fifo,
  output logic       o_block_en,
  output logic [4:0] o_round_state,
  output logic       o_last_round,
  output logic       o_out_valid,
  output logic       o_busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
  end

  logic [1:0] state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic       load;

  assign load = !i_fifo_empty && i_key_ready && !i_clear;

  // Output decode; everything is held low while reset is asserted so no pop can leak out.
  always_comb begin
    o_read_fifo   = n_rst && load && (state == IDLE || (state == DONE && i_out_ready));
    o_block_en    = o_read_fifo || (n_rst && state == RUN && !i_clear);
    o_last_round  = n_rst && state == RUN && cnt == LAST;
    o_out_valid   = n_rst && state == DONE && !i_clear;
    o_busy        = state != IDLE;
    o_round_state = cnt;
  end

  // Next state and round counter; abort wins over everything, a finished block may chain straight into the next.
  always_comb begin
    state_nx = IDLE;
    cnt_nx   = 5'd0;
    if (!i_clear) begin
      if (state == IDLE) begin
        state_nx = load ? RUN : IDLE;
        cnt_nx   = load ? 5'd1 : 5'd0;
      end else if (state == RUN) begin
        state_nx = (cnt < LAST) ? RUN : DONE;
        cnt_nx   = (cnt < LAST) ? cnt + 5'd1 : cnt;
      end else if (state == DONE) begin
        state_nx = !i_out_ready ? DONE : (load ? RUN : IDLE);
        cnt_nx   = !i_out_ready ? cnt : (load ? 5'd1 : 5'd0);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks plus a latency scoreboard over NUM_ROUNDS = 10, 12, 14
module tb_aes_round_sequencer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       key_ready = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] rd, en, last, vld, busy;
  logic [4:0] rs [3];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         q [3][$];
  int         rise [3];
  logic [2:0] pv = 3'b0;

  // Free-running clock and cycle index.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_sequencer #(.NUM_ROUNDS(10 + 2 * g)) dut (
      .clk(clk), .n_rst(n_rst), .i_fifo_empty(fifo_empty), .i_key_ready(key_ready),
      .i_clear(clr), .i_out_ready(out_ready), .o_read_fifo(rd[g]), .o_block_en(en[g]),
      .o_round_state(rs[g]), .o_last_round(last[g]), .o_out_valid(vld[g]), .o_busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each pop queues the cycle its ciphertext must become valid; each transfer retires one entry.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (clr || !n_rst) q[i].delete();
      else begin
        if (vld[i] && !pv[i]) rise[i] = cyc;
        if (vld[i] && out_ready) begin
          chk($sformatf("sb%0d_pending", i), q[i].size() != 0, 1);
          if (q[i].size() != 0) chk($sformatf("sb%0d_latency", i), rise[i], q[i].pop_front());
        end
        if (rd[i]) q[i].push_back(cyc + 11 + 2 * i);
      end
      pv[i] = vld[i];
    end
  end

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    fifo_empty = 1'b1;
    #1 chk("clear_outs", {rd, en, vld}, 0);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clear_idle", {busy, rs[0], rs[1], rs[2]}, 0);
  endtask

  initial begin
    fifo_empty = 1'b0;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset", {rd, en, last, vld, busy, rs[0]}, 0);
    fifo_empty = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    fifo_empty = 1'b0;
    #1 chk("t1_load", {rd[0], en[0], busy[0]}, 3'b110);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      fifo_empty = 1'b1;
      #1 chk($sformatf("t1_round%0d", r), {rd[0], en[0], last[0], vld[0], busy[0], rs[0]},
             {1'b0, 1'b1, r == 10, 1'b0, 1'b1, 5'(r)});
    end
    @(negedge clk);
    #1 chk("t1_valid", {rd[0], en[0], last[0], vld[0], rs[0]}, {4'b0001, 5'd10});
    @(negedge clk);
    #1 chk("t1_idle", {busy[0], vld[0], rs[0]}, 0);
    pulse_clear();
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      fifo_empty = k > 22;
      #1 chk($sformatf("b2b_k%0d", k), {rd[0], vld[0], busy[0]},
             {k == 0 || k == 11 || k == 22, k == 11 || k == 22 || k == 33, k >= 1 && k <= 33});
    end
    pulse_clear();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      fifo_empty = 1'b0;
      out_ready = k == 16;
      #1;
      if (k >= 11) chk($sformatf("bp_k%0d", k), {rd[0], en[0], vld[0], rs[0]}, {k == 16, k == 16, 1'b1, 5'd10});
    end
    pulse_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fifo_empty = 1'b0;
      key_ready = 1'b0;
      #1 chk($sformatf("gate_hold%0d", k), {rd[0], busy[0]}, 0);
    end
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      key_ready = k < 3;
      fifo_empty = k >= 11;
      #1 chk($sformatf("gate_k%0d", k), {rd[0], vld[0], busy[0], rs[0]},
             {k == 0, k == 11, k >= 1 && k <= 11, (k >= 1 && k <= 10) ? 5'(k) : (k == 11 ? 5'd10 : 5'd0)});
    end
    pulse_clear();
    key_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      fifo_empty = k != 0;
      clr = k == 5;
      #1 chk($sformatf("abort_k%0d", k), {rd[0], en[0], vld[0], busy[0], rs[0]},
             {k == 0, k < 5, 1'b0, k >= 1 && k <= 5, (k >= 1 && k <= 5) ? 5'(k) : 5'd0});
    end
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      fifo_empty = k != 0;
      #1;
    end
    chk("pre_reset_round", rs[0], 7);
    n_rst = 1'b0;
    fifo_empty = 1'b0;
    #1 chk("async_reset", {rd, en, last, vld, busy, rs[0], rs[1], rs[2]}, 0);
    @(negedge clk);
    #1 chk("reset_held", {rd, en, vld, busy}, 0);
    fifo_empty = 1'b1;
    n_rst = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      fifo_empty = k != 0;
      #1 chk($sformatf("sweep_k%0d", k), {vld[1], last[1], vld[2], last[2]}, {k == 13, k == 12, k == 15, k == 14});
      if (k == 14) chk("sweep_rs14", rs[2], 14);
    end
    @(negedge clk);
    #5 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
